// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B processed LSB first, one bit per
// clock, with a registered difference and final borrow.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_bit, b_bit, d_bit, br_nxt, last;

  // Full-subtractor cell on the current LSBs
  assign a_bit  = a_sr[0];
  assign b_bit  = b_sr[0];
  assign d_bit  = a_bit ^ b_bit ^ br;
  assign br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: RUN for WIDTH cycles, one DONE cycle, then back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_nxt;
          // Counter parks at its terminal value rather than wrapping
          if (!last) cnt <= cnt + CW'(1);
          if (last) begin
            Diff <= {d_bit, res_sr[WIDTH-1:1]};
            Bout <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): stimulus pushes expected
// {Diff,Bout}; a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] A, B;
  logic       busy, done, Bout;
  logic [3:0] Diff;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  logic [4:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare each done pulse against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        check("busy_done_exclusive", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("diff", {28'd0, Diff}, {28'd0, e[4:1]});
          check("bout", {31'd0, Bout}, {31'd0, e[0]});
        end
      end
    end
  end

  // One operation; optional scramble of A/B during RUN; checks busy length
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb, input bit scramble);
    int  busy_n;
    bit  seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    exp_q.push_back({ed, eb});
    @(posedge clk); #1 start = 1'b0;
    busy_n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (scramble && i == 0) begin A = 4'd0; B = 4'd15; end
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", busy_n, 32'd4);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {28'd0, Diff}, 32'd0);
    check("rst_bout", {31'd0, Bout}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    run_op(4'd9,  4'd3,  4'd6,  1'b0, 0);
    run_op(4'd3,  4'd9,  4'd10, 1'b1, 0);
    run_op(4'd0,  4'd1,  4'd15, 1'b1, 0);
    run_op(4'd15, 4'd15, 4'd0,  1'b0, 0);
    run_op(4'd12, 4'd4,  4'd8,  1'b0, 1);

    // Outputs hold after completion
    repeat (3) @(negedge clk);
    check("hold_diff", {28'd0, Diff}, 32'd8);
    check("hold_bout", {31'd0, Bout}, 32'd0);

    // start held high: done every 6 cycles at offsets 5, 11, 17
    @(negedge clk);
    A = 4'd7; B = 4'd2; start = 1'b1;
    repeat (3) exp_q.push_back({4'd5, 1'b0});
    @(posedge clk);
    dones = 0;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 17) start = 1'b0;
      if (done) begin
        dones++;
        check("b2b_done_pos", j % 6, 32'd5);
      end
    end
    check("b2b_done_count", dones, 32'd3);

    // Reset during the 2nd RUN cycle
    run_op(4'd5, 4'd6, 4'd15, 1'b1, 0);
    @(negedge clk);
    A = 4'd9; B = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_diff", {28'd0, Diff}, 32'd0);
    check("abort_bout", {31'd0, Bout}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    run_op(4'd5, 4'd6, 4'd15, 1'b1, 0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        logic [3:0] av, bv, dv;
        av = 4'(a); bv = 4'(b); dv = av - bv;
        run_op(av, bv, dv, (a < b), 0);
      end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the operand/result width in bits; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 Port A, input, WIDTH bits: minuend, unsigned; sampled on the edge that accepts start.
REQ-006 Port B, input, WIDTH bits: subtrahend, unsigned; sampled on the edge that accepts start.
REQ-007 Port busy, output, 1 bit: high while an operation is in progress (RUN state).
REQ-008 Port done, output, 1 bit: one-cycle pulse; Diff/Bout valid.
REQ-009 Port Diff, output, WIDTH bits: registered result (A - B) mod 2^WIDTH.
REQ-010 Port Bout, output, 1 bit: registered final borrow; 1 iff A < B (unsigned).

Function
REQ-011 FSM states SHALL be exactly IDLE, RUN and DONE, and the FSM SHALL be one-hot or binary encoded.
REQ-012 In IDLE with start=1 at a clock edge:
- latch A and B into operand shift registers;
- clear the borrow flip-flop and bit counter to 0;
- go to RUN.
REQ-013 In IDLE with start=0, the FSM SHALL remain in IDLE and hold all outputs.
REQ-014 In RUN, each edge SHALL process one bit, LSB first:
- d = a ^ b ^ br;
- br_next = (~a & b) | (~(a ^ b) & br);
- d is shifted into the result register;
- operands shift right;
- counter increments.
REQ-015 After exactly WIDTH RUN cycles, the FSM SHALL transfer the result register to Diff and the final br to Bout, then go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency: if start is accepted at edge k, then:
- busy SHALL be high from after edge k through edge k+WIDTH;
- done SHALL be high in the cycle following edge k+WIDTH;
- Diff/Bout SHALL change only at edge k+WIDTH.
REQ-018 start SHALL be ignored in RUN and DONE, with no effect on operands, counter or outputs; the next acceptance is possible from IDLE one cycle after done.
REQ-019 Diff and Bout SHALL hold their values from the end of an operation until the next completed operation.
REQ-020 A and B changes after acceptance SHALL NOT affect the operation in progress.
REQ-021 busy and done SHALL never be high in the same cycle.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, and its terminal count is WIDTH-1; there SHALL be no wrap-around beyond it.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk:
- force state IDLE;
- set busy=0, done=0, Diff=0, Bout=0;
- set the counter, borrow, operand and result registers to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation, with no done pulse and Diff/Bout=0.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 WIDTH=4, A=9, B=3, start pulse -> busy high 4 cycles, then done pulse, Diff=6, Bout=0.
REQ-027 A=3, B=9 -> Diff=10, Bout=1; A=0, B=1 -> Diff=15, Bout=1; A=15, B=15 -> Diff=0, Bout=0.
REQ-028 start held high continuously with A=7, B=2 -> operations complete back-to-back every 6 cycles (start accepted, 4 RUN, 1 DONE), Diff=5 each time, and start is ignored during busy.
REQ-029 A/B changed to 0/15 during RUN of A=12, B=4 -> Diff=8, Bout=0 (changes ignored).
REQ-030 rst_n pulsed low during the 2nd RUN cycle -> outputs 0 immediately, no done; a subsequent A=5, B=6 yields Diff=15, Bout=1.
REQ-031 Exhaustive WIDTH=4 sweep of all 256 A/B pairs -> Diff == (A-B) mod 16 and Bout == (A<B) for every pair, with done asserted exactly once per operation.
